// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the instruction fetch path: fetch FSM states,
// the buffered fetch entry layout and the word-alignment helper.
package cpu_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Instruction word in the upper half so the FIFO entry reads {inst, pc}
    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO; push is accepted when full if a pop happens in
// the same cycle. Flush empties it without moving the read pointer.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Keeping rd_ptr leaves the stale head visible, so outputs hold
            wr_ptr <= rd_ptr;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: sequential PC generation into a prefetch
// buffer with redirect and halt. Define IFETCH_BYPASS_EN to forward mem_inst
// straight to the consumer when the buffer is empty.
module ifetch_ctrl
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_out,
    output logic [WORD_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              fetch_busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [WORD_W-1:0] fetch_pc;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              fetching;
    logic              deq;
    logic              enq;
    logic              bypass_take;

    assign mem_addr   = word_align(fetch_pc);
    assign fetching   = (state == FETCH) && !redirect_valid;
    assign deq        = (fifo_count != '0) && inst_ready && !redirect_valid;
    assign push_entry = '{inst: mem_inst, pc: fetch_pc};

`ifdef IFETCH_BYPASS_EN
    logic bypass;

    assign bypass      = fetching && fifo_empty;
    assign bypass_take = bypass && inst_ready;
    assign inst_valid  = !fifo_empty || bypass;
    assign inst_out    = bypass ? mem_inst : head.inst;
    assign inst_pc     = bypass ? fetch_pc : head.pc;
`else
    assign bypass_take = 1'b0;
    assign inst_valid  = (fifo_count != '0);
    assign inst_out    = head.inst;
    assign inst_pc     = head.pc;
`endif

    // A bypassed word is consumed directly and must not also land in the buffer
    assign enq = fetching && (!fifo_full || deq) && !bypass_take;

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * WORD_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (enq),
        .pop   (deq),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
        end else if (enq || bypass_take) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    fetch_busy <= 1'b1;
                end
                FETCH: begin
                    if (halt_req) begin
                        state      <= HALTED;
                        fetch_busy <= 1'b0;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state      <= FETCH;
                        fetch_busy <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    fetch_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl (default build, DEPTH=4): startup latency,
// full-buffer stall, redirect flush, halt drain/resume and PC wraparound.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return (addr ^ 32'hC0DE_0000) + 32'h0000_1001;
    endfunction

    assign mem_inst = rom(mem_addr);

    ifetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .fetch_busy     (fetch_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pres(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst_out, rom(pc));
    endtask

    initial begin
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; halt_req = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // startup: IDLE one cycle, first FETCH, then one pc per cycle
        @(negedge clk); rst_n = 1'b1; inst_ready = 1'b1; #1;
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_busy", 32'(fetch_busy), 32'd0);
        chk("idle_valid", 32'(inst_valid), 32'd0);
        @(negedge clk); #1;
        chk("fetch0_busy", 32'(fetch_busy), 32'd1);
        chk("fetch0_addr", mem_addr, 32'd0);
        chk("fetch0_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            pres("stream", 32'(4 * i));
            chk("stream_addr", mem_addr, 32'(4 * i + 4));
        end

        // asynchronous reset mid-stream discards buffered entries at once
        @(negedge clk); rst_n = 1'b0; #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_busy", 32'(fetch_busy), 32'd0);
        chk("arst_pc", inst_pc, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);

        // stall: buffer saturates at 4 entries, mem_addr holds 0x10
        @(negedge clk); rst_n = 1'b1; inst_ready = 1'b0; #1;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk); #1;
            if (c >= 5) begin
                chk("full_addr", mem_addr, 32'h10);
                pres("full_head", 32'h0);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); inst_ready = 1'b1; #1;
            pres("drain", 32'(4 * i));
        end

        // one-cycle halt trims buffer to 3 entries
        @(negedge clk); halt_req = 1'b1; #1;
        pres("h0", 32'h18);
        chk("h0_busy", 32'(fetch_busy), 32'd1);
        @(negedge clk); halt_req = 1'b0; #1;
        pres("h1", 32'h1C);
        chk("h1_busy", 32'(fetch_busy), 32'd0);
        chk("h1_addr", mem_addr, 32'h2C);

        // redirect with 3 buffered: flush, realign 0x36 -> 0x34
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h36; #1;
        pres("redir_cyc", 32'h20);
        chk("redir_busy", 32'(fetch_busy), 32'd1);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("redir_valid", 32'(inst_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h34);
        @(negedge clk); inst_ready = 1'b0; #1;
        pres("redir_first", 32'h34);

        // halt for 5 cycles with 2 buffered: drain, no fetch, resume at 0x40
        @(negedge clk); inst_ready = 1'b1; halt_req = 1'b1; #1;
        pres("halt5_0", 32'h34);
        @(negedge clk); #1;
        pres("halt5_1", 32'h38);
        chk("halt5_busy", 32'(fetch_busy), 32'd0);
        chk("halt5_addr1", mem_addr, 32'h40);
        @(negedge clk); #1;
        pres("halt5_2", 32'h3C);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("halt5_empty", 32'(inst_valid), 32'd0);
            chk("halt5_addr", mem_addr, 32'h40);
        end
        @(negedge clk); halt_req = 1'b0; #1;
        chk("unhalt_busy", 32'(fetch_busy), 32'd0);
        chk("unhalt_valid", 32'(inst_valid), 32'd0);
        @(negedge clk); #1;
        chk("resume_busy", 32'(fetch_busy), 32'd1);
        chk("resume_addr", mem_addr, 32'h40);
        chk("resume_valid", 32'(inst_valid), 32'd0);

        // redirect to top of address space, pc wraps to 0
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        pres("resume_first", 32'h40);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("wrap_valid", 32'(inst_valid), 32'd0);
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        pres("wrap_top", 32'hFFFF_FFFC);
        @(negedge clk); #1;
        pres("wrap_zero", 32'h0);
        chk("wrap_next_addr", mem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
